// File: rtl/core_run_ctrl_if.sv
// Host load stream and instruction-memory write port between the host and the run controller.
interface core_run_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  ld_valid;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_waddr;
    logic [DATA_WIDTH-1:0] imem_wdata;

    modport master (
        output ld_valid, ld_data,
        input  ld_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  ld_valid, ld_data,
        output ld_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/core_run_ctrl.sv
// Run controller: loads the instruction image, then gates datapath reset/commit
// for run, halt, single-step and halt-on-EBREAK while counting retired instructions.
module core_run_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  run_req,
    input  logic                  halt_req,
    input  logic                  step_req,
    input  logic                  ebreak,
    output logic                  core_rst_n,
    output logic                  core_en,
    output logic [2:0]            state,
    output logic [31:0]           retired,
    core_run_ctrl_if.slave        ld
);
    localparam int unsigned LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_HALT = 3'd3,
        S_STEP = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [31:0]           retired_d;
    logic [LEN_W-1:0]      eff_len;
    logic                  accept;
    logic                  load_go;

    // A halt in LOAD suppresses that cycle's write even though ld_ready is up.
    assign accept        = ld.ld_valid & ld.ld_ready & ~halt_req;
    assign ld.imem_we    = accept;
    assign ld.imem_waddr = cnt_q;
    assign ld.imem_wdata = ld.ld_data;

    assign eff_len = (load_len > LEN_W'(IMEM_DEPTH)) ? LEN_W'(IMEM_DEPTH) : load_len;
    assign load_go = load_start & (load_len != '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        retired_d = retired;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (load_go) begin
                    state_d   = S_LOAD;
                    cnt_d     = '0;
                    last_d    = ADDR_WIDTH'(eff_len - LEN_W'(1));
                    retired_d = '0;
                end else if (run_req) begin
                    state_d = S_RUN;
                end else if (step_req && state_q == S_HALT) begin
                    state_d = S_STEP;
                end
            end
            S_LOAD: begin
                if (halt_req) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    if (cnt_q == last_q) state_d = S_IDLE;
                    else                 cnt_d   = cnt_q + ADDR_WIDTH'(1);
                end
            end
            S_RUN: begin
                retired_d = retired + 32'd1;
                if (ebreak || halt_req) state_d = S_HALT;
            end
            S_STEP: begin
                retired_d = retired + 32'd1;
                state_d   = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next state so they always match the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            retired     <= '0;
            core_rst_n  <= 1'b0;
            core_en     <= 1'b0;
            ld.ld_ready <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            retired     <= retired_d;
            core_rst_n  <= (state_d == S_RUN) || (state_d == S_HALT) || (state_d == S_STEP);
            core_en     <= (state_d == S_RUN) || (state_d == S_STEP);
            ld.ld_ready <= (state_d == S_LOAD);
        end
    end

    assign state = state_q;
endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: load, gap, run/ebreak, step, priority, abort, clamp, async reset.
module tb_core_run_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_start, run_req, halt_req, step_req, ebreak;
    logic [8:0]  load_len;
    logic        core_rst_n, core_en;
    logic [2:0]  state;
    logic [31:0] retired;
    int          checks = 0;
    int          failures = 0;
    int          wr_cnt = 0;
    int          wr_base;

    core_run_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) ld ();

    core_run_ctrl #(.ADDR_WIDTH(8), .IMEM_DEPTH(256), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .ebreak     (ebreak),
        .core_rst_n (core_rst_n),
        .core_en    (core_en),
        .state      (state),
        .retired    (retired),
        .ld         (ld.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ld.imem_we) wr_cnt <= wr_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] data, input logic [7:0] addr, input bit last);
        ld.ld_valid = 1'b1;
        ld.ld_data  = data;
        #1;
        check("we", 32'(ld.imem_we), 32'd1);
        check("waddr", 32'(ld.imem_waddr), 32'(addr));
        check("wdata", ld.imem_wdata, data);
        tick();
        check("state_after_word", 32'(state), last ? 32'd0 : 32'd1);
        check("ready_after_word", 32'(ld.ld_ready), last ? 32'd0 : 32'd1);
        ld.ld_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; load_start = 0; load_len = '0; run_req = 0; halt_req = 0;
        step_req = 0; ebreak = 0; ld.ld_valid = 0; ld.ld_data = '0;
        #3;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ready", 32'(ld.ld_ready), 32'd0);
        check("rst_we", 32'(ld.imem_we), 32'd0);
        check("rst_en", 32'(core_en), 32'd0);
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_retired", retired, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("idle_after_rst", 32'(state), 32'd0);

        // Test 1: three-word load with ld_valid held
        load_start = 1; load_len = 9'd3;
        tick();
        load_start = 0;
        check("t1_load_state", 32'(state), 32'd1);
        check("t1_ready", 32'(ld.ld_ready), 32'd1);
        check("t1_core_rst_n", 32'(core_rst_n), 32'd0);
        wr_base = wr_cnt;
        send_word(32'h00500093, 8'd0, 0);
        ld.ld_valid = 1'b1;
        send_word(32'h00108113, 8'd1, 0);
        ld.ld_valid = 1'b1;
        send_word(32'h00100073, 8'd2, 1);
        check("t1_writes", 32'(wr_cnt - wr_base), 32'd3);

        // Test 2: two-cycle valid gap mid-load, then zero-length request
        load_start = 1; load_len = 9'd4;
        tick();
        load_start = 0;
        wr_base = wr_cnt;
        send_word(32'hA0000000, 8'd0, 0);
        send_word(32'hA0000001, 8'd1, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t2_gap_we", 32'(ld.imem_we), 32'd0);
            tick();
            check("t2_gap_state", 32'(state), 32'd1);
        end
        send_word(32'hA0000002, 8'd2, 0);
        send_word(32'hA0000003, 8'd3, 1);
        check("t2_writes", 32'(wr_cnt - wr_base), 32'd4);
        load_start = 1; load_len = 9'd0;
        tick();
        load_start = 0;
        check("t2_len0_state", 32'(state), 32'd0);
        check("t2_len0_ready", 32'(ld.ld_ready), 32'd0);

        // Test 3: run then ebreak on the third RUN cycle
        run_req = 1;
        tick();
        run_req = 0;
        check("t3_run_state", 32'(state), 32'd2);
        check("t3_run_en", 32'(core_en), 32'd1);
        check("t3_run_rst_n", 32'(core_rst_n), 32'd1);
        tick();
        tick();
        check("t3_retired2", retired, 32'd2);
        ebreak = 1;
        tick();
        ebreak = 0;
        check("t3_halt_state", 32'(state), 32'd3);
        check("t3_halt_retired", retired, 32'd3);
        check("t3_halt_en", 32'(core_en), 32'd0);
        check("t3_halt_rst_n", 32'(core_rst_n), 32'd1);

        // Test 4: single steps, then a step with ebreak and run_req present
        for (int s = 0; s < 2; s++) begin
            step_req = 1;
            tick();
            step_req = 0;
            check("t4_step_state", 32'(state), 32'd4);
            check("t4_step_en", 32'(core_en), 32'd1);
            tick();
            check("t4_back_halt", 32'(state), 32'd3);
            check("t4_back_en", 32'(core_en), 32'd0);
            check("t4_retired", retired, 32'(4 + s));
        end
        step_req = 1; ebreak = 1;
        tick();
        step_req = 0; run_req = 1;
        check("t4_ebk_step", 32'(state), 32'd4);
        tick();
        run_req = 0; ebreak = 0;
        check("t4_ebk_halt", 32'(state), 32'd3);
        check("t4_ebk_retired", retired, 32'd6);

        // Test 5: load wins over run/step in HALT; halt aborts load without a write
        run_req = 1; step_req = 1; load_start = 1; load_len = 9'd2;
        tick();
        run_req = 0; step_req = 0; load_start = 0;
        check("t5_prio_state", 32'(state), 32'd1);
        check("t5_prio_rst_n", 32'(core_rst_n), 32'd0);
        check("t5_prio_en", 32'(core_en), 32'd0);
        check("t5_prio_retired", retired, 32'd0);
        ld.ld_valid = 1; ld.ld_data = 32'hDEADBEEF; halt_req = 1;
        #1;
        check("t5_abort_we", 32'(ld.imem_we), 32'd0);
        tick();
        ld.ld_valid = 0; halt_req = 0;
        check("t5_abort_state", 32'(state), 32'd0);

        // Oversized length clamps to memory depth
        load_start = 1; load_len = 9'd511;
        tick();
        load_start = 0;
        wr_base = wr_cnt;
        ld.ld_valid = 1;
        for (int i = 0; i < 255; i++) begin
            ld.ld_data = 32'(i);
            tick();
        end
        ld.ld_data = 32'h0000CAFE;
        #1;
        check("clamp_last_addr", 32'(ld.imem_waddr), 32'd255);
        tick();
        ld.ld_valid = 0;
        check("clamp_state", 32'(state), 32'd0);
        check("clamp_writes", 32'(wr_cnt - wr_base), 32'd256);

        // Test 6: asynchronous reset in RUN with retired=7
        run_req = 1;
        tick();
        run_req = 0;
        for (int i = 0; i < 7; i++) tick();
        check("t6_retired7", retired, 32'd7);
        rst = 1'b0;
        #1;
        check("t6_state", 32'(state), 32'd0);
        check("t6_en", 32'(core_en), 32'd0);
        check("t6_rst_n", 32'(core_rst_n), 32'd0);
        check("t6_retired", retired, 32'd0);
        rst = 1'b1;
        tick();
        check("t6_post_state", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Run controller for the single-cycle core datapath.
- Loads the instruction memory image from a host word stream over a valid/ready handshake, then holds the datapath in reset or releases it.
- Gates instruction commit: run, halt, single-step, and halt-on-EBREAK.
- Counts retired instructions; sits between the host/debug interface and the DataPath top.

Parameters:
ADDR_WIDTH, 8, instruction memory word-address width
IMEM_DEPTH, 256, instruction memory depth in words (≤ 2**ADDR_WIDTH)
DATA_WIDTH, 32, instruction word width

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-low reset
load_start  input  1  request image load (sampled in IDLE/HALT)
load_len  input  ADDR_WIDTH+1  number of words to load, sampled with load_start
ld_valid  input  1  host word valid
ld_data  input  DATA_WIDTH  host word
ld_ready  output  1  controller accepts word
imem_we  output  1  instruction memory write enable
imem_waddr  output  ADDR_WIDTH  instruction memory write address
imem_wdata  output  DATA_WIDTH  instruction memory write data
run_req  input  1  start/resume free-running
halt_req  input  1  stop commit / abort load
step_req  input  1  execute exactly one instruction from HALT
ebreak  input  1  datapath decodes EBREAK this cycle
core_rst_n  output  1  active-low reset to the datapath
core_en  output  1  datapath commit enable (PC update, regfile/memory write)
state  output  3  IDLE=0, LOAD=1, RUN=2, HALT=3, STEP=4
retired  output  32  retired-instruction count

Behaviour:
Reset (rst=0, async):
- state=IDLE, word counter=0, retired=0.
- ld_ready=0, imem_we=0, core_en=0, core_rst_n=0.
- Reset mid-load or mid-run aborts immediately. No pending request survives.

Output decode (from state register only; no combinational input-to-output path except the load write port):
- core_rst_n=1 iff state ∈ {RUN, HALT, STEP}.
- core_en=1 iff state ∈ {RUN, STEP}.
- ld_ready=1 iff state=LOAD.
- Load write port: imem_we = ld_valid & ld_ready; imem_waddr = word counter; imem_wdata = ld_data. Zero-latency write.

IDLE:
- load_start with load_len≠0 → LOAD. Counter cleared; retired cleared. Effective length = min(load_len, IMEM_DEPTH).
- load_start with load_len=0 is ignored and state stays IDLE.
- Else run_req → RUN, which executes the existing image from reset PC.
- load_start has priority over run_req.

LOAD:
- Each ld_valid & ld_ready accepts one word; counter increments.
- Acceptance of the last word (counter = len−1) → IDLE. Counter is not advanced past len−1.
- halt_req → IDLE (abort). Words already written persist. halt_req wins over a same-cycle word acceptance; that word is not written.
- load_start, run_req, step_req ignored.

RUN:
- retired += 1 every cycle (wraps at 2**32).
- ebreak or halt_req → HALT. The EBREAK cycle's instruction counts as retired and its commit occurs.
- run_req, step_req, load_start ignored.

HALT:
- Datapath state is preserved (core_rst_n=1, core_en=0).
- Priority: load_start (len≠0) → LOAD, which drives core_rst_n=0 and clears retired; then run_req → RUN; then step_req → STEP.
- halt_req and ebreak are no-ops.

STEP:
- Exactly one cycle with core_en=1; retired += 1.
- Next state unconditionally HALT, including when ebreak=1 or run_req=1.

Test Plan:
1. Reset release → state=0, all outputs 0. load_start with load_len=3, then words 0x00500093, 0x00108113, 0x00100073 with ld_valid held → imem_we on 3 consecutive cycles, addr 0,1,2, ld_ready low after the 3rd word, state=IDLE.
2. Host drops ld_valid for 2 cycles mid-load → no writes during the gap, addresses stay contiguous, exactly load_len writes total. load_len=0 → state stays IDLE.
3. run_req from IDLE → core_rst_n=1 and core_en=1 the next cycle. ebreak after 3 RUN cycles → state=HALT, retired=3, core_en=0, core_rst_n stays 1.
4. From HALT, step_req pulse twice → core_en high exactly 1 cycle each, retired 3→4→5. step_req with ebreak=1 → returns to HALT.
5. HALT with run_req, step_req, load_start all asserted together → LOAD taken, core_rst_n=0, retired=0. halt_req concurrent with ld_valid in LOAD → no write that cycle, state=IDLE.
6. Assert rst low during RUN (retired=7) → asynchronous clear: state=IDLE, core_en=0, core_rst_n=0, retired=0 before the next clk edge.
